// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, data-SRAM request, forwarding and a restoring divider.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 141,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    ex_wreg,
    output logic [4:0]              ex_waddr,
    output logic [31:0]             ex_wdata,
    output logic                    ex_opl,
    output logic                    stallreq
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    logic [ID_TO_EX_WD-1:0] id_to_ex_r;
    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2, ram_wen;
    logic        ram_en, rf_we, sel_rf_res;
    logic [4:0]  rf_waddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        id_to_ex_r <= '0;
        else if (stall[2] && !stall[3]) id_to_ex_r <= '0;
        else if (!stall[2])             id_to_ex_r <= id_to_ex_bus;
    end

    assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = id_to_ex_r;

    logic unused_bits;
    assign unused_bits = ^{stall[STALL_WD-1:4], stall[1:0], inst[25:16]};

    logic [31:0] src1, src2, ex_result;

    always_comb begin
        src1 = '0;
        if (sel_src1[0])      src1 = rdata1;
        else if (sel_src1[1]) src1 = pc;
        else if (sel_src1[2]) src1 = {27'd0, inst[10:6]};
    end

    always_comb begin
        src2 = '0;
        if (sel_src2[0])      src2 = rdata2;
        else if (sel_src2[1]) src2 = {{16{inst[15]}}, inst[15:0]};
        else if (sel_src2[2]) src2 = 32'd8;
        else if (sel_src2[3]) src2 = {16'd0, inst[15:0]};
    end

    always_comb begin
        ex_result = '0;
        if (alu_op[11])     ex_result = src1 + src2;
        else if (alu_op[10]) ex_result = src1 - src2;
        else if (alu_op[9])  ex_result = {31'd0, $signed(src1) < $signed(src2)};
        else if (alu_op[8])  ex_result = {31'd0, src1 < src2};
        else if (alu_op[7])  ex_result = src1 & src2;
        else if (alu_op[6])  ex_result = ~(src1 | src2);
        else if (alu_op[5])  ex_result = src1 | src2;
        else if (alu_op[4])  ex_result = src1 ^ src2;
        else if (alu_op[3])  ex_result = src2 << src1[4:0];
        else if (alu_op[2])  ex_result = src2 >> src1[4:0];
        else if (alu_op[1])  ex_result = $signed(src2) >>> src1[4:0];
        else if (alu_op[0])  ex_result = {src2[15:0], 16'd0};
    end

    logic is_div, is_divu, is_div_op;
    assign is_div    = (inst[31:26] == 6'd0) && (inst[5:0] == 6'h1A);
    assign is_divu   = (inst[5:0] == 6'h1B);
    assign is_div_op = is_div || is_divu;

    div_state_t state, state_nx;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvs, hi_r, lo_r, quo_nx, rem_nx;
    logic        neg_q, neg_r, hilo_we;
    logic [32:0] rem_shift, diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // DONE is left only when the input register takes a new value, so a held divide never restarts
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (is_div_op) state_nx = (rdata2 == 32'd0) ? S_DONE : S_BUSY;
            S_BUSY: if (cnt == 5'd31) state_nx = S_DONE;
            S_DONE: if (!(stall[2] && stall[3])) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        stallreq = 1'b0;
        hilo_we  = 1'b0;
        if (is_div_op) begin
            stallreq = (state != S_DONE);
            hilo_we  = (state == S_DONE);
        end
    end

    // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits
    always_comb begin
        rem_shift = {rem, quo[31]};
        diff      = rem_shift - {1'b0, dvs};
        rem_nx    = diff[32] ? rem_shift[31:0] : diff[31:0];
        quo_nx    = {quo[30:0], ~diff[32]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0; quo <= '0; rem <= '0; dvs <= '0;
            neg_q <= 1'b0; neg_r <= 1'b0; hi_r <= '0; lo_r <= '0;
        end else begin
            case (state)
                S_IDLE: if (is_div_op) begin
                    if (rdata2 != 32'd0) begin
                        quo   <= (is_div && rdata1[31]) ? 32'd0 - rdata1 : rdata1;
                        dvs   <= (is_div && rdata2[31]) ? 32'd0 - rdata2 : rdata2;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= is_div && (rdata1[31] ^ rdata2[31]);
                        neg_r <= is_div && rdata1[31];
                    end else begin
                        lo_r <= 32'hFFFF_FFFF;
                        hi_r <= rdata1;
                    end
                end
                S_BUSY: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        lo_r <= neg_q ? 32'd0 - quo_nx : quo_nx;
                        hi_r <= neg_r ? 32'd0 - rem_nx : rem_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = rdata2;
    assign ex_wreg         = rf_we;
    assign ex_waddr        = rf_waddr;
    assign ex_wdata        = ex_result;
    assign ex_opl          = ram_en & sel_rf_res;

    assign ex_to_mem_bus = {hilo_we, hilo_we ? hi_r : 32'd0, hilo_we ? lo_r : 32'd0, pc,
                            ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};

endmodule
